// File: rtl/frame_color_classifier_if.sv
// Pixel-stream and result bundle for frame_color_classifier.
// The master side is the pixel source / result consumer, the slave side is the classifier.
interface frame_color_classifier_if #(
    parameter int CNT_W = 16
) ();
    logic              start;
    logic              pix_valid;
    logic [15:0]       pix_data;
    logic              pix_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  red_count;
    logic [CNT_W-1:0]  green_count;
    logic [CNT_W-1:0]  blue_count;
    logic [2:0]        dominant;
    logic              none;

    modport master (
        output start, pix_valid, pix_data,
        input  pix_ready, busy, done, red_count, green_count, blue_count, dominant, none
    );

    modport slave (
        input  start, pix_valid, pix_data,
        output pix_ready, busy, done, red_count, green_count, blue_count, dominant, none
    );
endinterface

// File: rtl/frame_color_classifier.sv
// Streaming dominant-colour classifier for RGB565 frames.
// Accepts N_PIXELS pixels per start, classifies each by a ratio test, keeps
// saturating per-class counts and reports a one-hot dominant colour at frame end.
module frame_color_classifier #(
    parameter int N_PIXELS  = 256,
    parameter int CNT_W     = 16,
    parameter int RATIO     = 2,
    parameter int MIN_COUNT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    frame_color_classifier_if.slave  io_pix
);
    // Product width: 6-bit channel times RATIO never overflows this.
    localparam int PW = 6 + $clog2(RATIO + 1);
    localparam int AW = $clog2(N_PIXELS + 1);

    localparam logic [PW-1:0]    RATIO_P  = PW'(RATIO);
    localparam logic [AW-1:0]    LAST_IDX = AW'(N_PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_COUNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + CNT_W'(1);
        end else begin
            return cnt;
        end
    endfunction

    // Frame verdict {dominant[2:0], none}: a colour wins only with a strict
    // maximum that also reaches MIN_COUNT; anything else is "none".
    function automatic logic [3:0] f_result(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
        logic [2:0] dom;
        dom[2] = (r > g) && (r > b) && (r >= MIN_C);
        dom[1] = (g > r) && (g > b) && (g >= MIN_C);
        dom[0] = (b > r) && (b > g) && (b >= MIN_C);
        return {dom, (dom == 3'b000)};
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_start_go;
    logic              w_accept;

    logic [AW-1:0]     r_acc_cnt;
    logic [2:0]        r_flag;
    logic [CNT_W-1:0]  r_red_count;
    logic [CNT_W-1:0]  r_green_count;
    logic [CNT_W-1:0]  r_blue_count;
    logic [CNT_W-1:0]  w_red_nxt;
    logic [CNT_W-1:0]  w_green_nxt;
    logic [CNT_W-1:0]  w_blue_nxt;

    logic              r_pix_ready;
    logic              r_busy;
    logic              r_done;
    logic [2:0]        r_dominant;
    logic              r_none;

    // Channel normalisation: R and B gain a zero LSB so all channels are 6-bit.
    logic [PW-1:0]     w_r6;
    logic [PW-1:0]     w_g6;
    logic [PW-1:0]     w_b6;
    logic [PW-1:0]     w_r_x;
    logic [PW-1:0]     w_g_x;
    logic [PW-1:0]     w_b_x;
    logic [2:0]        w_cls;

    assign w_r6  = {{(PW-6){1'b0}}, io_pix.pix_data[15:11], 1'b0};
    assign w_g6  = {{(PW-6){1'b0}}, io_pix.pix_data[10:5]};
    assign w_b6  = {{(PW-6){1'b0}}, io_pix.pix_data[4:0], 1'b0};
    assign w_r_x = w_r6 * RATIO_P;
    assign w_g_x = w_g6 * RATIO_P;
    assign w_b_x = w_b6 * RATIO_P;

    // Class flags {red, green, blue}; with RATIO >= 1 at most one can be set.
    always_comb begin
        w_cls    = 3'b000;
        w_cls[2] = (w_r6 > w_g_x) && (w_r6 > w_b_x);
        w_cls[1] = (w_g6 > w_r_x) && (w_g6 > w_b_x);
        w_cls[0] = (w_b6 > w_r_x) && (w_b6 > w_g_x);
    end

    // Frame sequencing: next state, start acceptance and pixel acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_start_go  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (io_pix.start) begin
                    w_start_go  = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RUN: begin
                w_accept = io_pix.pix_valid;
                if (w_accept && (r_acc_cnt == LAST_IDX)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage-2 counter values; also the final counts the verdict is built from.
    always_comb begin
        w_red_nxt   = f_sat_inc(r_red_count,   r_flag[2]);
        w_green_nxt = f_sat_inc(r_green_count, r_flag[1]);
        w_blue_nxt  = f_sat_inc(r_blue_count,  r_flag[0]);
    end

    // State register and registered handshake outputs derived from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix_ready <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done      <= (r_state == S_DRAIN);
        end
    end

    // Two-stage datapath: flags of the accepted pixel, then the class counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_cnt     <= '0;
            r_flag        <= 3'b000;
            r_red_count   <= '0;
            r_green_count <= '0;
            r_blue_count  <= '0;
        end else if (w_start_go) begin
            r_acc_cnt     <= '0;
            r_flag        <= 3'b000;
            r_red_count   <= '0;
            r_green_count <= '0;
            r_blue_count  <= '0;
        end else begin
            r_acc_cnt     <= w_accept ? (r_acc_cnt + AW'(1)) : r_acc_cnt;
            r_flag        <= w_accept ? w_cls : 3'b000;
            r_red_count   <= w_red_nxt;
            r_green_count <= w_green_nxt;
            r_blue_count  <= w_blue_nxt;
        end
    end

    // Verdict captured on the DRAIN->DONE transition and held until the next one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dominant <= 3'b000;
            r_none     <= 1'b1;
        end else if (r_state == S_DRAIN) begin
            {r_dominant, r_none} <= f_result(w_red_nxt, w_green_nxt, w_blue_nxt);
        end else begin
            r_dominant <= r_dominant;
            r_none     <= r_none;
        end
    end

    assign io_pix.pix_ready   = r_pix_ready;
    assign io_pix.busy        = r_busy;
    assign io_pix.done        = r_done;
    assign io_pix.red_count   = r_red_count;
    assign io_pix.green_count = r_green_count;
    assign io_pix.blue_count  = r_blue_count;
    assign io_pix.dominant    = r_dominant;
    assign io_pix.none        = r_none;
endmodule
